bcd_updn_ctr: RTL and testbench
===============================

Name: bcd_updn_ctr

Overview:
Parametrised multi-digit BCD up/down counter. It generalises the single-digit BCD counter to DIGITS decades with a ripple-free synchronous carry/borrow chain. It adds count enable, synchronous clear, validated parallel load, a wrap-or-saturate mode, and terminal-count and overflow flags. It is used as a decade counter for display and timer blocks, and it can be cascaded through tc.

Parameters:
DIGITS, 4, number of BCD decades (1..8); q width is 4*DIGITS
WRAP, 1, 1 = wrap at the terminal count (9..9 -> 0..0 up, 0..0 -> 9..9 down); 0 = saturate and hold at the terminal count

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-low; asserting it (low) clears all state immediately
en  input  1  count enable
ud  input  1  direction: 1 = up, 0 = down
clr  input  1  synchronous clear to zero
load  input  1  synchronous parallel load
d  input  4*DIGITS  load value; digit i is d[4i+3:4i], and digit 0 is least significant
q  output  4*DIGITS  counter value in BCD; digit i is q[4i+3:4i]
tc  output  1  combinational terminal count: en & ((ud & all q digits==9) | (!ud & all q digits==0))
ovf  output  1  registered one-cycle pulse; set on the edge where the counter wraps, or is held by saturation, at the terminal count
load_err  output  1  registered one-cycle pulse; set when a load is rejected

Behaviour:
- Reset (rst low, asynchronous): q=0, ovf=0, load_err=0. Release is synchronous to the next clk edge; counting resumes on the first edge with rst high.
- Per-edge priority: clr > load > en. Inputs with lower priority are ignored in that cycle.
- clr=1: q <= 0. ovf and load_err are cleared to 0.
- load=1, clr=0:
  - If every digit of d is <=9, q <= d and load_err <= 0.
  - If any digit of d is >9, q is held and load_err <= 1 for exactly one cycle.
  - ovf <= 0 in either case.
- en=1, clr=0, load=0, ud=1:
  - Digit i increments when every digit below it is 9; digit 0 always increments.
  - An incrementing digit that is 9 becomes 0; otherwise it becomes digit+1.
- en=1, ud=0:
  - Digit i decrements when every digit below it is 0.
  - A decrementing digit that is 0 becomes 9.
- Terminal count (tc=1) on an enabled edge:
  - WRAP=1: q takes the wrapped value (all 0 going up, all 9 going down) and ovf <= 1.
  - WRAP=0: q is held and ovf <= 1. ovf stays 1 on every subsequent enabled edge while q remains at the terminal count and the direction still points past it.
- Otherwise ovf <= 0 and load_err <= 0 on every edge; both are pulses, not sticky.
- en=0: q is held and ovf <= 0.
- ud may change on any cycle and takes effect on that same edge, with no turnaround cycle. Example: q=0..0 with ud=0 is the terminal count; with ud=1 it counts to 0..01.
- Latency: every change to q appears one clk edge after the inputs are sampled. tc follows q, en and ud combinationally within the same cycle.
- Non-BCD states (any digit >9) are unreachable, because reset, clear and validated load are the only ways to set q.
- Cascading: the tc of a lower instance drives the en of a higher instance. The ud of both instances must be tied together.

Test Plan:
All scenarios use DIGITS=4, WRAP=1 unless stated otherwise.
- rst low mid-count at q=0x0537, asynchronously between edges -> q=0x0000, ovf=0 and load_err=0 immediately; after rst rises, 3 enabled up edges -> q=0x0003.
- Load d=0x0999, then en=1, ud=1, one edge -> q=0x1000 (three-digit carry ripple in one cycle). Then ud=0, one edge -> q=0x0999.
- Load d=0x9998, en=1, ud=1 -> tc=0 at 0x9998; next edge q=0x9999 and tc=1; next edge q=0x0000 with ovf=1 for one cycle only.
- WRAP=0: from q=0x0001, en=1, ud=0 -> edge 1: q=0x0000, tc=1, ovf=0; edges 2 and 3: q holds 0x0000 and ovf=1 on each; then ud=1 -> q=0x0001, ovf=0.
- From q=0x0042, load d=0x12A4 -> q stays 0x0042, load_err=1 for one cycle. load with clr=1 in the same cycle -> q=0x0000, load_err=0.
- From q=0x0100, en=0 for 5 edges -> q stays 0x0100 and tc=0. Then en=1, ud=0 -> q=0x0099.

Source files
------------

// File: rtl/bcd_updn_ctr.sv
// Multi-decade BCD up/down counter with clear, validated parallel load,
// wrap-or-saturate terminal handling, terminal-count and overflow flags.
module bcd_updn_ctr #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  ud,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  ovf,
    output logic                  load_err
);

    logic [4*DIGITS-1:0] q_nxt;
    logic                all9;
    logic                all0;
    logic                d_ok;

    // up_c/dn_c carry "all lower digits are 9/0" along the chain, so every
    // digit's step is decided in one cycle without rippling through registers.
    always_comb begin
        logic       up_c;
        logic       dn_c;
        logic [3:0] dig;
        q_nxt = '0;
        d_ok  = 1'b1;
        up_c  = 1'b1;
        dn_c  = 1'b1;
        dig   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            dig = q[4*i +: 4];
            if (ud)
                q_nxt[4*i +: 4] = up_c ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
            else
                q_nxt[4*i +: 4] = dn_c ? ((dig == 4'd0) ? 4'd9 : dig - 4'd1) : dig;
            up_c = up_c & (dig == 4'd9);
            dn_c = dn_c & (dig == 4'd0);
            if (d[4*i +: 4] > 4'd9)
                d_ok = 1'b0;
        end
        all9 = up_c;
        all0 = dn_c;
    end

    assign tc = en & ((ud & all9) | (~ud & all0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q        <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (clr) begin
            q        <= '0;
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            if (d_ok)
                q <= d;
            load_err <= ~d_ok;
            ovf      <= 1'b0;
        end else if (en) begin
            // At the terminal count the natural next value is already the
            // wrapped one; saturation simply suppresses the update.
            if (!tc || WRAP)
                q <= q_nxt;
            ovf      <= tc;
            load_err <= 1'b0;
        end else begin
            ovf      <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updn_ctr.sv
// Scoreboard bench for bcd_updn_ctr: a wrapping and a saturating instance
// share stimulus; expectations are queued and checked by a monitor process.
module tb_bcd_updn_ctr;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, ud = 1'b1, clr = 1'b0, load = 1'b0;
    logic [15:0] d = '0;

    logic [15:0] q_w, q_s;
    logic        tc_w, tc_s, ovf_w, ovf_s, le_w, le_s;

    typedef struct {
        bit          sel;
        logic [15:0] q;
        logic        ovf;
        logic        le;
        logic        tc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    bcd_updn_ctr #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .clr(clr), .load(load), .d(d),
        .q(q_w), .tc(tc_w), .ovf(ovf_w), .load_err(le_w)
    );

    bcd_updn_ctr #(.DIGITS(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .ud(ud), .clr(clr), .load(load), .d(d),
        .q(q_s), .tc(tc_s), .ovf(ovf_s), .load_err(le_s)
    );

    always #5 clk = ~clk;

    function automatic void cmp(input string nm, input string fld,
                                input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    cmp(e.name, "q",   q_s,           e.q);
                    cmp(e.name, "ovf", {15'd0, ovf_s}, {15'd0, e.ovf});
                    cmp(e.name, "le",  {15'd0, le_s},  {15'd0, e.le});
                    cmp(e.name, "tc",  {15'd0, tc_s},  {15'd0, e.tc});
                end else begin
                    cmp(e.name, "q",   q_w,           e.q);
                    cmp(e.name, "ovf", {15'd0, ovf_w}, {15'd0, e.ovf});
                    cmp(e.name, "le",  {15'd0, le_w},  {15'd0, e.le});
                    cmp(e.name, "tc",  {15'd0, tc_w},  {15'd0, e.tc});
                end
            end
        end
    end

    task automatic tick(input logic e_i, input logic u_i, input logic c_i,
                        input logic l_i, input logic [15:0] d_i);
        @(negedge clk);
        en = e_i; ud = u_i; clr = c_i; load = l_i; d = d_i;
        @(posedge clk);
    endtask

    task automatic push_exp(input bit sel, input logic [15:0] eq, input logic eo,
                            input logic el, input logic et, input string nm);
        exp_t e;
        e.sel = sel; e.q = eq; e.ovf = eo; e.le = el; e.tc = et; e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        push_exp(0, 16'h0000, 0, 0, 0, "reset_init");
        @(negedge clk);
        rst = 1'b1;

        // asynchronous reset mid-count
        tick(0, 1, 0, 1, 16'h0537); push_exp(0, 16'h0537, 0, 0, 0, "ld0537");
        @(negedge clk);
        load = 1'b0;
        #2 rst = 1'b0;
        push_exp(0, 16'h0000, 0, 0, 0, "async_rst");
        @(negedge clk);
        rst = 1'b1;
        tick(1, 1, 0, 0, 16'h0); push_exp(0, 16'h0001, 0, 0, 0, "rel_up1");
        tick(1, 1, 0, 0, 16'h0); push_exp(0, 16'h0002, 0, 0, 0, "rel_up2");
        tick(1, 1, 0, 0, 16'h0); push_exp(0, 16'h0003, 0, 0, 0, "rel_up3");

        // carry / borrow across three digits
        tick(0, 1, 0, 1, 16'h0999); push_exp(0, 16'h0999, 0, 0, 0, "ld0999");
        tick(1, 1, 0, 0, 16'h0);    push_exp(0, 16'h1000, 0, 0, 0, "carry3");
        tick(1, 0, 0, 0, 16'h0);    push_exp(0, 16'h0999, 0, 0, 0, "borrow3");

        // up wrap at 9999
        tick(0, 1, 0, 1, 16'h9998); push_exp(0, 16'h9998, 0, 0, 0, "ld9998");
        tick(1, 1, 0, 0, 16'h0);    push_exp(0, 16'h9999, 0, 0, 1, "to9999");
        tick(1, 1, 0, 0, 16'h0);    push_exp(0, 16'h0000, 1, 0, 0, "wrap_up");
        tick(1, 1, 0, 0, 16'h0);    push_exp(0, 16'h0001, 0, 0, 0, "ovf_pulse");

        // down to zero: saturating instance holds, wrapping instance wraps
        tick(0, 0, 0, 1, 16'h0001);
        push_exp(1, 16'h0001, 0, 0, 0, "sat_ld");
        push_exp(0, 16'h0001, 0, 0, 0, "wrp_ld");
        tick(1, 0, 0, 0, 16'h0);
        push_exp(1, 16'h0000, 0, 0, 1, "sat_e1");
        push_exp(0, 16'h0000, 0, 0, 1, "wrp_e1");
        tick(1, 0, 0, 0, 16'h0);
        push_exp(1, 16'h0000, 1, 0, 1, "sat_e2");
        push_exp(0, 16'h9999, 1, 0, 0, "wrp_dn");
        tick(1, 0, 0, 0, 16'h0);
        push_exp(1, 16'h0000, 1, 0, 1, "sat_e3");
        push_exp(0, 16'h9998, 0, 0, 0, "wrp_dn2");
        tick(1, 1, 0, 0, 16'h0);
        push_exp(1, 16'h0001, 0, 0, 0, "sat_up");
        push_exp(0, 16'h9999, 0, 0, 1, "wrp_tc_up");

        // rejected load, then clr overriding load
        tick(0, 1, 0, 1, 16'h0042); push_exp(0, 16'h0042, 0, 0, 0, "ld0042");
        tick(0, 1, 0, 1, 16'h12A4); push_exp(0, 16'h0042, 0, 1, 0, "ld_bad");
        tick(0, 1, 0, 0, 16'h0);    push_exp(0, 16'h0042, 0, 0, 0, "le_pulse");
        tick(0, 1, 1, 1, 16'h12A4); push_exp(0, 16'h0000, 0, 0, 0, "clr_ld");

        // hold with en low, then borrow
        tick(0, 0, 0, 1, 16'h0100); push_exp(0, 16'h0100, 0, 0, 0, "ld0100");
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 16'h0); push_exp(0, 16'h0100, 0, 0, 0, "hold");
        end
        tick(1, 0, 0, 0, 16'h0); push_exp(0, 16'h0099, 0, 0, 0, "dn0099");

        tick(0, 1, 0, 0, 16'h0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors += sb.size();
            $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
